// File: rtl/ls161_timer_ctrl_if.sv
// Host/counter-side signal bundle for the LS161 timer controller.
// master = host plus counter side, slave = the controller itself.
interface ls161_timer_ctrl_if #(
    parameter int WRAP_W = 8
);
    logic              START;
    logic              ABORT;
    logic              PAUSE;
    logic              PERIODIC;
    logic [3:0]        PRELOAD;
    logic [WRAP_W-1:0] NUM_WRAPS;
    logic [3:0]        Q_IN;
    logic              CNT_CLR_n;
    logic              CNT_LOAD_n;
    logic [3:0]        CNT_D;
    logic              CNT_ENP;
    logic              CNT_ENT;
    logic              BUSY;
    logic              EXPIRE;
    logic [WRAP_W-1:0] WRAPS;

    modport master (
        output START, ABORT, PAUSE, PERIODIC, PRELOAD, NUM_WRAPS, Q_IN,
        input  CNT_CLR_n, CNT_LOAD_n, CNT_D, CNT_ENP, CNT_ENT, BUSY, EXPIRE, WRAPS
    );

    modport slave (
        input  START, ABORT, PAUSE, PERIODIC, PRELOAD, NUM_WRAPS, Q_IN,
        output CNT_CLR_n, CNT_LOAD_n, CNT_D, CNT_ENP, CNT_ENT, BUSY, EXPIRE, WRAPS
    );
endinterface

// File: rtl/ls161_timer_ctrl.sv
// Controller for an external 4-bit LS161 counter: preload, run N wraps (F->0),
// pulse EXPIRE, optionally reload and repeat.
module ls161_timer_ctrl #(
    parameter int WRAP_W = 8
) (
    input  logic              CLK,
    input  logic              CLR,
    ls161_timer_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        preload_q;
    logic [3:0]        q_prev;
    logic              en_prev;
    logic              periodic_q;
    logic [WRAP_W-1:0] target_q;
    logic [WRAP_W-1:0] wraps_q;
    logic [WRAP_W-1:0] wraps_inc;
    logic              wrap;
    logic              start_ok;
    logic              enp, ent;

    // Wrap is seen one cycle late: the F->0 step must have been an enabled count.
    assign wrap      = en_prev & (q_prev == 4'hF) & (bus.Q_IN == 4'h0);
    assign wraps_inc = wraps_q + WRAP_W'(1);
    assign start_ok  = (state == IDLE) & bus.START & ~bus.ABORT;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = LOAD;
            LOAD:    state_nxt = RUN;
            RUN:     if (wrap && wraps_inc == target_q) state_nxt = DONE;
            DONE:    state_nxt = periodic_q ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE && bus.ABORT) state_nxt = IDLE;
    end

    always_comb begin
        bus.CNT_CLR_n  = 1'b1;
        bus.CNT_LOAD_n = 1'b1;
        bus.CNT_D      = 4'h0;
        bus.BUSY       = 1'b1;
        bus.EXPIRE     = 1'b0;
        enp            = 1'b0;
        ent            = 1'b0;
        case (state)
            IDLE: begin
                bus.CNT_CLR_n = 1'b0;
                bus.BUSY      = 1'b0;
            end
            LOAD: begin
                bus.CNT_LOAD_n = 1'b0;
                bus.CNT_D      = preload_q;
            end
            RUN: begin
                ent = 1'b1;
                enp = ~bus.PAUSE;
            end
            DONE:    bus.EXPIRE = 1'b1;
            default: ;
        endcase
        bus.CNT_ENP = enp;
        bus.CNT_ENT = ent;
        bus.WRAPS   = wraps_q;
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state      <= IDLE;
            preload_q  <= 4'h0;
            q_prev     <= 4'h0;
            en_prev    <= 1'b0;
            periodic_q <= 1'b0;
            target_q   <= '0;
            wraps_q    <= '0;
        end else begin
            state   <= state_nxt;
            q_prev  <= bus.Q_IN;
            en_prev <= enp & ent;
            if (start_ok) begin
                preload_q  <= bus.PRELOAD;
                periodic_q <= bus.PERIODIC;
                target_q   <= (bus.NUM_WRAPS == '0) ? WRAP_W'(1) : bus.NUM_WRAPS;
            end
            // ABORT freezes WRAPS so the host can read how far the period got.
            if (!bus.ABORT) begin
                if (state == LOAD)
                    wraps_q <= '0;
                else if (state == RUN && wrap)
                    wraps_q <= wraps_inc;
            end
        end
    end
endmodule
